// File: rtl/pc_fetch_stage.sv
// rtl/pc_fetch_stage.sv - instruction fetch stage: PC register, imem request, IF/ID register
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] pc_next_i,
    input  logic        hazard_stall_i,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ready_i,
    input  logic [31:0] imem_data_i,
    output logic [31:0] pc_o,
    output logic [31:0] ifid_pc_o,
    output logic [31:0] ifid_instr_o,
    output logic        ifid_valid_o,
    output logic        fetch_busy_o,
    output logic [31:0] fetch_cnt_o
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] fetch_cnt_q, fetch_cnt_d;

    logic in_fetch;
    logic accept;

    assign in_fetch = (state_q == ST_FETCH);
    // A fetch is accepted only when nothing of higher priority blocks it.
    assign accept   = in_fetch && start_i && !hazard_stall_i && imem_ready_i;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;
        ifid_valid_d = ifid_valid_q;
        fetch_cnt_d  = fetch_cnt_q;

        if (!in_fetch) begin
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
            if (start_i) begin
                state_d = ST_FETCH;
            end
        end else if (!start_i) begin
            state_d      = ST_IDLE;
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else if (hazard_stall_i) begin
            // Stall wins over a branch target; returned data is dropped and refetched.
            if (flush_i) begin
                ifid_pc_d    = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end
        end else if (!imem_ready_i) begin
            ifid_pc_d    = 32'h0;
            ifid_instr_d = NOP_INSTR;
            ifid_valid_d = 1'b0;
        end else begin
            pc_d        = pc_next_i;
            fetch_cnt_d = fetch_cnt_q + 32'd1;
            if (flush_i) begin
                ifid_pc_d    = 32'h0;
                ifid_instr_d = NOP_INSTR;
                ifid_valid_d = 1'b0;
            end else begin
                ifid_pc_d    = pc_q;
                ifid_instr_d = imem_data_i;
                ifid_valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ifid_pc_q    <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_valid_q <= 1'b0;
            fetch_cnt_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            fetch_cnt_q  <= fetch_cnt_d;
        end
    end

    assign imem_req_o   = in_fetch;
    assign imem_addr_o  = pc_q;
    assign pc_o         = pc_q;
    assign ifid_pc_o    = ifid_pc_q;
    assign ifid_instr_o = ifid_instr_q;
    assign ifid_valid_o = ifid_valid_q;
    assign fetch_busy_o = in_fetch && !imem_ready_i;
    assign fetch_cnt_o  = fetch_cnt_q;

    logic unused_accept;
    assign unused_accept = accept;

endmodule

// File: tb/tb_pc_fetch_stage.sv
// tb/tb_pc_fetch_stage.sv - directed self-checking bench for pc_fetch_stage
module tb_pc_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] pc_next = 32'h0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        ready = 1'b0;
    logic [31:0] data = 32'h0;
    logic        req;
    logic [31:0] addr, pc, ifid_pc, ifid_instr, cnt;
    logic        ifid_valid, busy;

    int n_cmp = 0;
    int n_err = 0;

    pc_fetch_stage dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .pc_next_i(pc_next),
        .hazard_stall_i(stall), .flush_i(flush), .imem_req_o(req),
        .imem_addr_o(addr), .imem_ready_i(ready), .imem_data_i(data),
        .pc_o(pc), .ifid_pc_o(ifid_pc), .ifid_instr_o(ifid_instr),
        .ifid_valid_o(ifid_valid), .fetch_busy_o(busy), .fetch_cnt_o(cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0; ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (pc !== 32'h0) begin n_err++; $display("FAIL reset_pc got=%h exp=%h", pc, 32'h0); end
        n_cmp++; if (ifid_instr !== 32'h13) begin n_err++; $display("FAIL reset_instr got=%h exp=%h", ifid_instr, 32'h13); end
        n_cmp++; if (ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin n_err++; $display("FAIL reset_ifid got v=%b pc=%h exp v=0 pc=0", ifid_valid, ifid_pc); end
        n_cmp++; if (req !== 1'b0 || cnt !== 32'h0) begin n_err++; $display("FAIL reset_req_cnt got req=%b cnt=%h exp 0/0", req, cnt); end
        // Idle keeps request low and PC at reset value
        step();
        n_cmp++; if (req !== 1'b0 || pc !== 32'h0) begin n_err++; $display("FAIL idle_hold got req=%b pc=%h exp 0/0", req, pc); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        n_cmp++; if (req !== 1'b1 || pc !== 32'h0 || ifid_valid !== 1'b0) begin n_err++; $display("FAIL seq_enter got req=%b pc=%h v=%b exp 1/0/0", req, pc, ifid_valid); end
        exp_pc = 32'h0;
        for (int i = 0; i < 4; i++) begin
            pc_next = pc + 32'd4;
            data = 32'hA000_0000 | exp_pc;
            step();
            n_cmp++; if (pc !== exp_pc + 32'd4) begin n_err++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, pc, exp_pc + 32'd4); end
            n_cmp++; if (ifid_pc !== exp_pc || ifid_instr !== (32'hA000_0000 | exp_pc) || ifid_valid !== 1'b1) begin
                n_err++; $display("FAIL seq_ifid[%0d] got pc=%h instr=%h v=%b exp pc=%h instr=%h v=1", i, ifid_pc, ifid_instr, ifid_valid, exp_pc, 32'hA000_0000 | exp_pc);
            end
            exp_pc = exp_pc + 32'd4;
        end
        n_cmp++; if (cnt !== 32'd4) begin n_err++; $display("FAIL seq_cnt got=%0d exp=4", cnt); end
        n_cmp++; if (addr !== 32'd16) begin n_err++; $display("FAIL seq_addr got=%h exp=%h", addr, 32'd16); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        for (int i = 0; i < 2; i++) begin pc_next = pc + 32'd4; data = 32'h1111_0000 + pc; step(); end
        ready = 1'b0; pc_next = 32'h0000_0FF0;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL wait_busy got=%b exp=1", busy); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (pc !== 32'd8 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || cnt !== 32'd2) begin
                n_err++; $display("FAIL wait_hold[%0d] got pc=%h v=%b instr=%h cnt=%0d exp pc=8 v=0 instr=13 cnt=2", i, pc, ifid_valid, ifid_instr, cnt);
            end
        end
        ready = 1'b1; pc_next = 32'd12; data = 32'h00C0_0113;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wait_busy_clear got=%b exp=0", busy); end
        step();
        n_cmp++; if (ifid_pc !== 32'd8 || ifid_instr !== 32'h00C0_0113 || ifid_valid !== 1'b1 || pc !== 32'd12 || cnt !== 32'd3) begin
            n_err++; $display("FAIL wait_resume got pc=%h ifpc=%h instr=%h v=%b cnt=%0d exp 12/8/00c00113/1/3", pc, ifid_pc, ifid_instr, ifid_valid, cnt);
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        pc_next = 32'd4; data = 32'h0000_0093; step();
        pc_next = 32'd8; data = 32'h00A0_0093; step();
        stall = 1'b1; pc_next = 32'h100; data = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++; if (pc !== 32'd8 || ifid_pc !== 32'd4 || ifid_instr !== 32'h00A0_0093 || ifid_valid !== 1'b1 || cnt !== 32'd2) begin
                n_err++; $display("FAIL stall_hold[%0d] got pc=%h ifpc=%h instr=%h v=%b cnt=%0d exp 8/4/00a00093/1/2", i, pc, ifid_pc, ifid_instr, ifid_valid, cnt);
            end
        end
        flush = 1'b1;
        step();
        n_cmp++; if (pc !== 32'd8 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || cnt !== 32'd2) begin
            n_err++; $display("FAIL stall_flush got pc=%h v=%b instr=%h cnt=%0d exp 8/0/13/2", pc, ifid_valid, ifid_instr, cnt);
        end
        stall = 1'b0; flush = 1'b1; pc_next = 32'h40; data = 32'h1234_5678;
        step();
        n_cmp++; if (pc !== 32'h40 || ifid_valid !== 1'b0 || cnt !== 32'd3) begin
            n_err++; $display("FAIL flush_accept got pc=%h v=%b cnt=%0d exp 40/0/3", pc, ifid_valid, cnt);
        end
        flush = 1'b0; pc_next = 32'h44; data = 32'h0050_0213;
        step();
        n_cmp++; if (ifid_pc !== 32'h40 || ifid_instr !== 32'h0050_0213 || ifid_valid !== 1'b1 || pc !== 32'h44) begin
            n_err++; $display("FAIL flush_next got ifpc=%h instr=%h v=%b pc=%h exp 40/00500213/1/44", ifid_pc, ifid_instr, ifid_valid, pc);
        end
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        pc_next = 32'h20; step();
        ready = 1'b0; pc_next = 32'h80;
        step();
        n_cmp++; if (pc !== 32'h20 || req !== 1'b1) begin n_err++; $display("FAIL mid_setup got pc=%h req=%b exp 20/1", pc, req); end
        rst = 1'b1;
        step();
        n_cmp++; if (pc !== 32'h0 || req !== 1'b0 || cnt !== 32'h0 || busy !== 1'b0) begin
            n_err++; $display("FAIL mid_reset got pc=%h req=%b cnt=%0d busy=%b exp 0/0/0/0", pc, req, cnt, busy);
        end
        rst = 1'b0;
        step();
        n_cmp++; if (req !== 1'b1 || pc !== 32'h0) begin n_err++; $display("FAIL mid_restart got req=%b pc=%h exp 1/0", req, pc); end
    endtask

    task automatic test_wrap_and_stop();
        do_reset();
        start = 1'b1; ready = 1'b1;
        step();
        force dut.fetch_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_cnt_q;
        pc_next = 32'h200; data = 32'h0000_0013;
        step();
        n_cmp++; if (cnt !== 32'h0) begin n_err++; $display("FAIL cnt_wrap got=%h exp=%h", cnt, 32'h0); end
        n_cmp++; if (pc !== 32'h200) begin n_err++; $display("FAIL wrap_pc got=%h exp=%h", pc, 32'h200); end
        start = 1'b0; pc_next = 32'h300;
        step();
        n_cmp++; if (req !== 1'b0 || pc !== 32'h200 || ifid_valid !== 1'b0 || cnt !== 32'h0) begin
            n_err++; $display("FAIL stop got req=%b pc=%h v=%b cnt=%h exp 0/200/0/0", req, pc, ifid_valid, cnt);
        end
        step();
        n_cmp++; if (req !== 1'b0 || pc !== 32'h200) begin n_err++; $display("FAIL stop_hold got req=%b pc=%h exp 0/200", req, pc); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_mem_wait();
        test_stall_flush();
        test_reset_mid_fetch();
        test_wrap_and_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Instruction-fetch stage directly downstream of the PC select mux.
- Owns the PC register and drives the instruction-memory request.
- Owns the IF/ID pipeline register that feeds decode.
- Consumes the mux's next-PC value; honours hazard stall, branch flush and a memory-ready handshake, so a slow instruction memory stalls fetch without corrupting the pipeline.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, instruction word inserted into IF/ID for a bubble (addi x0,x0,0)

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  synchronous reset, active-high
start_i  input  1  fetch enable; fetch runs only while high
pc_next_i  input  32  next PC from PC select mux
hazard_stall_i  input  1  load-use stall: hold PC and IF/ID
flush_i  input  1  branch taken in ID: squash the IF/ID entry
imem_req_o  output  1  instruction-memory read request
imem_addr_o  output  32  read address, always equal to pc_o
imem_ready_i  input  1  memory returns valid data this cycle
imem_data_i  input  32  instruction word, valid when imem_ready_i=1
pc_o  output  32  current PC (to mux and PC+4 adder)
ifid_pc_o  output  32  PC of the instruction held in IF/ID
ifid_instr_o  output  32  instruction held in IF/ID
ifid_valid_o  output  1  IF/ID holds a real instruction
fetch_busy_o  output  1  fetch is waiting on memory (combinational: FETCH and !imem_ready_i)
fetch_cnt_o  output  32  count of accepted fetches

Behaviour:
- Reset (rst_i=1 at an edge, any state, overrides all other inputs):
  - PC=RESET_PC; state=IDLE; fetch_cnt_o=0.
  - IF/ID=bubble: ifid_pc_o=0, ifid_instr_o=NOP_INSTR, ifid_valid_o=0.
  - imem_req_o=0.
  - Reset mid-fetch drops the outstanding request with no memory-side handshake.
- States: IDLE, FETCH. imem_req_o=1 only in FETCH.
- IDLE:
  - PC holds; IF/ID loads bubble each cycle.
  - start_i=1 -> FETCH next cycle.
- FETCH, evaluated each edge in this priority order:
  1. start_i=0 -> IDLE; PC holds; IF/ID <= bubble.
  2. hazard_stall_i=1 -> PC holds; IF/ID holds, or becomes bubble if flush_i=1. Data returned this cycle is discarded and refetched next cycle; no count.
  3. imem_ready_i=0 -> PC holds; IF/ID <= bubble. flush_i is irrelevant because the result is a bubble either way.
  4. imem_ready_i=1 (accepted fetch):
     - PC <= pc_next_i.
     - IF/ID <= bubble if flush_i=1, else {pc_o, imem_data_i, valid=1}.
     - fetch_cnt_o += 1 in both cases.
- Stall has priority over branch for the PC, matching mux select priority. A branch target presented during a stall is not taken; the branch unit must re-present it.
- Latency: an instruction accepted at edge N appears on ifid_* immediately after edge N. With imem_ready_i tied high, one instruction per cycle.
- fetch_cnt_o wraps 32'hFFFFFFFF -> 0 silently.
- No combinational path from pc_next_i to any output.

Test Plan:
- Reset then start_i=1, imem_ready_i=1, pc_next_i=pc_o+4, 4 cycles -> pc_o=0,4,8,12,16; ifid_pc_o=0,4,8,12; ifid_valid_o=1; fetch_cnt_o=4.
- At PC=8, imem_ready_i=0 for 3 cycles -> pc_o stays 8; fetch_busy_o=1; ifid_valid_o=0 and ifid_instr_o=32'h13 for 3 cycles; fetch_cnt_o unchanged; next ready cycle latches PC 8.
- hazard_stall_i=1 for 2 cycles with IF/ID={4, 32'h00A00093} -> pc_o and IF/ID unchanged; fetch_cnt_o unchanged.
- flush_i=1 with imem_ready_i=1 and pc_next_i=32'h40 -> pc_o=32'h40; ifid_valid_o=0; fetch_cnt_o increments. Next cycle ifid_pc_o=32'h40.
- rst_i=1 during FETCH wait with pc_o=32'h20 -> next cycle pc_o=0, state IDLE, imem_req_o=0, fetch_cnt_o=0.
- Preload fetch_cnt_o to 32'hFFFFFFFF via 2^32-1 accepted fetches (or force), one more accepted fetch -> fetch_cnt_o=0. Drop start_i mid-run -> imem_req_o=0 next cycle and pc_o holds.
